// File: rtl/peripheral_uart_rx_drain_wb.sv
// RX FIFO drain controller: moves UART receive FIFO entries onto a valid/ready
// byte stream in bounded bursts and raises trigger/timeout/error interrupts.
module peripheral_uart_rx_drain_wb #(
    parameter int FIFO_COUNTER_W = 5,
    parameter int REC_W          = 11,
    parameter int MAX_BURST      = 8,
    parameter int DROP_ERR       = 0
) (
    input  logic                      clk,
    input  logic                      wb_rst_i,
    input  logic                      ctrl_en,
    input  logic [1:0]                trig_lvl,
    input  logic [2:0]                ie,
    input  logic                      irq_clr,
    input  logic [FIFO_COUNTER_W-1:0] rf_count,
    input  logic [REC_W-1:0]          rf_data_out,
    input  logic [9:0]                counter_t,
    output logic                      rf_pop,
    output logic                      m_valid,
    output logic [7:0]                m_data,
    output logic [2:0]                m_err,
    input  logic                      m_ready,
    output logic [7:0]                err_cnt,
    output logic                      irq,
    output logic                      busy
);

    typedef enum logic [1:0] {IDLE, ARM, LOAD, SEND} state_t;

    localparam logic [FIFO_COUNTER_W-1:0] LP_MAX = FIFO_COUNTER_W'(MAX_BURST);

    state_t                    r_state;
    state_t                    w_next;
    logic [4:0]                r_rem;
    logic                      r_m_valid;
    logic [7:0]                r_m_data;
    logic [2:0]                r_m_err;
    logic [7:0]                r_err_cnt;
    logic                      r_irq;
    logic                      r_busy;
    logic                      r_tout_f;
    logic                      r_err_f;
    logic                      r_trig_f;

    logic [FIFO_COUNTER_W-1:0] w_thr;
    logic                      w_tout;
    logic                      w_start;
    logic                      w_load_ok;
    logic                      w_pop;
    logic                      w_entry_err;
    logic                      w_drop;
    logic [4:0]                w_rem_dec;
    logic [4:0]                w_burst;

    always_comb begin
        w_thr = FIFO_COUNTER_W'(1);
        case (trig_lvl)
            2'b01:   w_thr = FIFO_COUNTER_W'(4);
            2'b10:   w_thr = FIFO_COUNTER_W'(8);
            2'b11:   w_thr = FIFO_COUNTER_W'(14);
            default: w_thr = FIFO_COUNTER_W'(1);
        endcase
    end

    assign w_tout      = (counter_t == 10'd0) && (rf_count != '0);
    assign w_start     = ctrl_en && ((rf_count >= w_thr) || w_tout);
    assign w_load_ok   = ctrl_en && (rf_count != '0) && (r_rem != 5'd0);
    assign w_entry_err = |rf_data_out[2:0];
    assign w_drop      = (DROP_ERR != 0) && w_entry_err;
    assign w_rem_dec   = r_rem - 5'd1;
    assign w_burst     = (rf_count > LP_MAX) ? 5'(LP_MAX) : 5'(rf_count);

    // The pop strobe is decoded from the registered LOAD state so the abort
    // check and the FIFO head are evaluated in the same cycle as the pop.
    assign w_pop       = (r_state == LOAD) && w_load_ok;

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_start) w_next = ARM;
            ARM:  w_next = LOAD;
            LOAD: begin
                if (!w_load_ok)              w_next = IDLE;
                else if (w_drop)             w_next = (w_rem_dec != 5'd0) ? LOAD : IDLE;
                else                         w_next = SEND;
            end
            SEND: if (m_ready)           w_next = (r_rem != 5'd0) ? LOAD : IDLE;
            default:                     w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_rem     <= 5'd0;
            r_m_valid <= 1'b0;
            r_m_data  <= 8'd0;
            r_m_err   <= 3'd0;
            r_err_cnt <= 8'd0;
            r_irq     <= 1'b0;
            r_busy    <= 1'b0;
            r_tout_f  <= 1'b0;
            r_err_f   <= 1'b0;
            r_trig_f  <= 1'b0;
        end else begin
            if (r_state == ARM) r_rem <= w_burst;
            else if (w_pop)     r_rem <= w_rem_dec;

            if (w_pop) begin
                r_m_data <= rf_data_out[REC_W-1 -: 8];
                r_m_err  <= rf_data_out[2:0];
            end

            r_m_valid <= (w_next == SEND);
            r_busy    <= (w_next != IDLE);

            if (w_pop && w_entry_err && (r_err_cnt != 8'hFF))
                r_err_cnt <= r_err_cnt + 8'd1;

            // Sticky flags: a new set condition wins over a same-cycle clear.
            if (w_tout)                  r_tout_f <= 1'b1;
            else if (w_pop || irq_clr)   r_tout_f <= 1'b0;

            if (w_pop && w_entry_err)    r_err_f <= 1'b1;
            else if (irq_clr)            r_err_f <= 1'b0;

            r_trig_f <= (rf_count >= w_thr);
            r_irq    <= |({r_err_f, r_tout_f, r_trig_f} & ie);
        end
    end

    assign rf_pop  = w_pop;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_err   = r_m_err;
    assign err_cnt = r_err_cnt;
    assign irq     = r_irq;
    assign busy    = r_busy;

endmodule

// File: tb/tb_peripheral_uart_rx_drain_wb.sv
// Directed bench for the RX drain controller: two instances (forward and drop
// error entries) each fed by a small behavioral receive FIFO.
module tb_peripheral_uart_rx_drain_wb;

    localparam int CW = 5;
    localparam int RW = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          wb_rst_i;
    logic          ctrl_en;
    logic [1:0]    trig_lvl;
    logic [2:0]    ie;
    logic          irq_clr;
    logic [9:0]    counter_t;
    logic          m_ready;

    logic [RW-1:0] memA [0:63];
    logic [RW-1:0] memB [0:63];
    logic [5:0]    headA = '0, tailA = '0, headB = '0, tailB = '0;
    logic          pushA = 1'b0, pushB = 1'b0, flushA = 1'b0;
    logic [RW-1:0] pushDat = '0;
    logic [CW-1:0] rfCountA, rfCountB;
    logic [RW-1:0] rfDataA, rfDataB;

    logic          rfPopA, mValidA, irqA, busyA;
    logic [7:0]    mDataA, errCntA;
    logic [2:0]    mErrA;
    logic          rfPopB, mValidB, irqB, busyB;
    logic [7:0]    mDataB, errCntB;
    logic [2:0]    mErrB;

    assign rfCountA = CW'(tailA - headA);
    assign rfCountB = CW'(tailB - headB);
    assign rfDataA  = memA[headA];
    assign rfDataB  = memB[headB];

    peripheral_uart_rx_drain_wb #(
        .FIFO_COUNTER_W(CW), .REC_W(RW), .MAX_BURST(8), .DROP_ERR(0)
    ) dutA (
        .clk(clk), .wb_rst_i(wb_rst_i), .ctrl_en(ctrl_en), .trig_lvl(trig_lvl),
        .ie(ie), .irq_clr(irq_clr), .rf_count(rfCountA), .rf_data_out(rfDataA),
        .counter_t(counter_t), .rf_pop(rfPopA), .m_valid(mValidA), .m_data(mDataA),
        .m_err(mErrA), .m_ready(m_ready), .err_cnt(errCntA), .irq(irqA), .busy(busyA)
    );

    peripheral_uart_rx_drain_wb #(
        .FIFO_COUNTER_W(CW), .REC_W(RW), .MAX_BURST(8), .DROP_ERR(1)
    ) dutB (
        .clk(clk), .wb_rst_i(wb_rst_i), .ctrl_en(ctrl_en), .trig_lvl(trig_lvl),
        .ie(ie), .irq_clr(irq_clr), .rf_count(rfCountB), .rf_data_out(rfDataB),
        .counter_t(counter_t), .rf_pop(rfPopB), .m_valid(mValidB), .m_data(mDataB),
        .m_err(mErrB), .m_ready(m_ready), .err_cnt(errCntB), .irq(irqB), .busy(busyB)
    );

    // Behavioral receive FIFOs: entries survive DUT reset, head advances on pop.
    always @(posedge clk) begin
        if (flushA)      headA <= tailA;
        else if (rfPopA) headA <= headA + 6'd1;
        if (pushA) begin
            memA[tailA] <= pushDat;
            tailA       <= tailA + 6'd1;
        end
        if (rfPopB) headB <= headB + 6'd1;
        if (pushB) begin
            memB[tailB] <= pushDat;
            tailB       <= tailB + 6'd1;
        end
    end

    int            cyc = 0, lastPushA = 0;
    int            nPopA = 0, nSendA = 0, nPopB = 0, nSendB = 0;
    int            irqCntA = 0, stabErrA = 0;
    int            nBurstA = 0, popsInBurstA = 0;
    int            popCycA [0:63];
    int            burstLogA [0:15];
    logic [10:0]   sendLogA [0:63];
    logic [10:0]   sendLogB [0:63];
    logic          holdA = 1'b0;
    logic [10:0]   holdValA = '0;

    // Event logs of pops, handshakes, bursts, irq cycles and stall stability.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pushA) lastPushA <= cyc;
        if (rfPopA) begin
            popCycA[nPopA[5:0]] <= cyc;
            nPopA               <= nPopA + 1;
            popsInBurstA        <= popsInBurstA + 1;
        end else if (!busyA && popsInBurstA != 0) begin
            burstLogA[nBurstA[3:0]] <= popsInBurstA;
            nBurstA                 <= nBurstA + 1;
            popsInBurstA            <= 0;
        end
        if (mValidA && m_ready) begin
            sendLogA[nSendA[5:0]] <= {mErrA, mDataA};
            nSendA                <= nSendA + 1;
        end
        if (rfPopB) nPopB <= nPopB + 1;
        if (mValidB && m_ready) begin
            sendLogB[nSendB[5:0]] <= {mErrB, mDataB};
            nSendB                <= nSendB + 1;
        end
        if (irqA) irqCntA <= irqCntA + 1;
        if (holdA && mValidA && ({mErrA, mDataA} != holdValA)) stabErrA <= stabErrA + 1;
        holdA    <= mValidA && !m_ready;
        holdValA <= {mErrA, mDataA};
    end

    int testsRun    = 0;
    int testsFailed = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [10:0] entry, input logic toA, input logic toB);
        pushDat = entry;
        pushA   = toA;
        pushB   = toB;
        @(negedge clk);
        pushA   = 1'b0;
        pushB   = 1'b0;
    endtask

    task automatic waitSendsA(input int target, input int budget);
        for (int i = 0; i < budget && nSendA < target; i++) @(negedge clk);
    endtask

    task automatic waitValidA(input int budget);
        for (int i = 0; i < budget && !mValidA; i++) @(negedge clk);
    endtask

    int s0, p0, i0, b0, sB0, pB0;

    initial begin
        wb_rst_i  = 1'b1;
        ctrl_en   = 1'b0;
        trig_lvl  = 2'b00;
        ie        = 3'b000;
        irq_clr   = 1'b0;
        counter_t = 10'd100;
        m_ready   = 1'b0;
        waitCycles(3);

        checkOutput("rst m_valid", mValidA, 1'b0);
        checkOutput("rst rf_pop",  rfPopA,  1'b0);
        checkOutput("rst busy",    busyA,   1'b0);
        checkOutput("rst irq",     irqA,    1'b0);
        checkOutput("rst m_data",  mDataA,  8'h00);
        checkOutput("rst m_err",   mErrA,   3'b000);
        checkOutput("rst err_cnt", errCntA, 8'h00);
        wb_rst_i = 1'b0;
        waitCycles(2);

        // Trigger bursts at level 4: first with irq masked, then enabled.
        for (int burst = 0; burst < 2; burst++) begin
            ie       = (burst == 0) ? 3'b000 : 3'b001;
            trig_lvl = 2'b01;
            ctrl_en  = 1'b1;
            m_ready  = 1'b1;
            s0 = nSendA; p0 = nPopA; i0 = irqCntA;
            for (int i = 0; i < 4; i++) applyStimulus({8'(8'h41 + i), 3'b000}, 1'b1, 1'b0);
            waitSendsA(s0 + 4, 60);
            waitCycles(4);
            checkOutput("trig sends", nSendA - s0, 4);
            for (int i = 0; i < 4; i++)
                checkOutput("trig data", sendLogA[6'(s0 + i)], {3'b000, 8'(8'h41 + i)});
            checkOutput("trig first pop latency", popCycA[6'(p0)] - lastPushA, 3);
            for (int i = 1; i < 4; i++)
                checkOutput("trig pop spacing", popCycA[6'(p0 + i)] - popCycA[6'(p0 + i - 1)], 2);
            checkOutput("trig irq cycles", irqCntA - i0, (burst == 0) ? 0 : 3);
        end

        // Character timeout below the trigger level.
        ie       = 3'b010;
        trig_lvl = 2'b11;
        s0 = nSendA; p0 = nPopA;
        applyStimulus({8'h31, 3'b000}, 1'b1, 1'b0);
        applyStimulus({8'h32, 3'b000}, 1'b1, 1'b0);
        waitCycles(3);
        checkOutput("tout no early pop", nPopA - p0, 0);
        i0 = irqCntA;
        counter_t = 10'd0;
        @(negedge clk);
        counter_t = 10'd100;
        waitSendsA(s0 + 2, 40);
        waitCycles(4);
        checkOutput("tout irq cycles", irqCntA - i0, 2);
        checkOutput("tout data0", sendLogA[6'(s0)],     11'h031);
        checkOutput("tout data1", sendLogA[6'(s0 + 1)], 11'h032);
        checkOutput("tout irq cleared by pop", irqA, 1'b0);

        // Burst cap with random backpressure: 12 entries split 8 + 4.
        ie       = 3'b000;
        trig_lvl = 2'b00;
        ctrl_en  = 1'b0;
        m_ready  = 1'b0;
        s0 = nSendA; b0 = nBurstA; i0 = stabErrA;
        for (int i = 0; i < 12; i++) applyStimulus({8'(8'h10 + i), 3'b000}, 1'b1, 1'b0);
        ctrl_en = 1'b1;
        for (int i = 0; i < 400 && nSendA < s0 + 12; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        m_ready = 1'b1;
        waitCycles(6);
        checkOutput("cap sends", nSendA - s0, 12);
        for (int i = 0; i < 12; i++)
            checkOutput("cap data", sendLogA[6'(s0 + i)], {3'b000, 8'(8'h10 + i)});
        checkOutput("cap bursts", nBurstA - b0, 2);
        checkOutput("cap burst0 pops", burstLogA[4'(b0)],     8);
        checkOutput("cap burst1 pops", burstLogA[4'(b0 + 1)], 4);
        checkOutput("cap stall stable", stabErrA - i0, 0);

        // Error entries: forwarded by instance A, dropped by instance B.
        ie      = 3'b100;
        ctrl_en = 1'b0;
        s0 = nSendA; sB0 = nSendB; pB0 = nPopB;
        applyStimulus({8'h55, 3'b001}, 1'b1, 1'b1);
        applyStimulus({8'h66, 3'b000}, 1'b1, 1'b1);
        ctrl_en = 1'b1;
        for (int i = 0; i < 60 && (nSendA < s0 + 2 || nSendB < sB0 + 1); i++) @(negedge clk);
        waitCycles(4);
        checkOutput("err A sends", nSendA - s0, 2);
        checkOutput("err A entry0", sendLogA[6'(s0)],     11'h155);
        checkOutput("err A entry1", sendLogA[6'(s0 + 1)], 11'h066);
        checkOutput("err B sends", nSendB - sB0, 1);
        checkOutput("err B entry0", sendLogB[6'(sB0)], 11'h066);
        checkOutput("err B pops", nPopB - pB0, 2);
        checkOutput("err A err_cnt", errCntA, 8'd1);
        checkOutput("err B err_cnt", errCntB, 8'd1);
        checkOutput("err A irq", irqA, 1'b1);
        checkOutput("err B irq", irqB, 1'b1);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        @(negedge clk);
        checkOutput("err A irq cleared", irqA, 1'b0);
        checkOutput("err B irq cleared", irqB, 1'b0);
        checkOutput("err A err_cnt kept", errCntA, 8'd1);

        // ctrl_en drop during a stall: current byte delivered, then no pop.
        ie      = 3'b000;
        ctrl_en = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus({8'(8'h71 + i), 3'b000}, 1'b1, 1'b0);
        s0 = nSendA; p0 = nPopA;
        ctrl_en = 1'b1;
        waitValidA(20);
        checkOutput("abort valid", mValidA, 1'b1);
        ctrl_en = 1'b0;
        waitCycles(3);
        checkOutput("abort valid held", mValidA, 1'b1);
        checkOutput("abort data held", mDataA, 8'h71);
        m_ready = 1'b1;
        waitCycles(8);
        checkOutput("abort sends", nSendA - s0, 1);
        checkOutput("abort pops", nPopA - p0, 1);
        checkOutput("abort busy", busyA, 1'b0);
        checkOutput("abort fifo left", rfCountA, 5'd2);

        // FIFO flushed to empty mid-burst.
        m_ready = 1'b0;
        s0 = nSendA; p0 = nPopA;
        ctrl_en = 1'b1;
        waitValidA(20);
        checkOutput("flush data", mDataA, 8'h72);
        flushA = 1'b1;
        @(negedge clk);
        flushA  = 1'b0;
        m_ready = 1'b1;
        waitCycles(8);
        checkOutput("flush pops", nPopA - p0, 1);
        checkOutput("flush sends", nSendA - s0, 1);
        checkOutput("flush busy", busyA, 1'b0);
        checkOutput("flush fifo empty", rfCountA, 5'd0);
        ctrl_en = 1'b0;

        // Asynchronous reset while stalled in SEND.
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus({8'(8'h81 + i), 3'b000}, 1'b1, 1'b0);
        ctrl_en = 1'b1;
        waitValidA(20);
        checkOutput("mid-burst valid", mValidA, 1'b1);
        checkOutput("pre-reset err_cnt", errCntA, 8'd1);
        #2 wb_rst_i = 1'b1;
        #1;
        checkOutput("async rst m_valid", mValidA, 1'b0);
        checkOutput("async rst rf_pop",  rfPopA,  1'b0);
        checkOutput("async rst err_cnt", errCntA, 8'd0);
        checkOutput("async rst busy",    busyA,   1'b0);
        ctrl_en = 1'b0;
        @(negedge clk);
        wb_rst_i = 1'b0;
        waitCycles(2);
        checkOutput("rst fifo kept", rfCountA, 5'd2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
